// File: rtl/ibex_pkg.sv
// Shared constants and the xorshift32 step function for the IPM random-source stage.
package ibex_pkg;

    localparam logic [31:0] IPM_PRNG_DEFAULT_SEED = 32'h0000_0001;

    // One xorshift32 step; maps every nonzero state onto another nonzero state.
    function automatic logic [31:0] ipm_xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/ipm_prng_fifo.sv
// Synchronous FIFO with push/pop/flush and a registered head word that reads zero when empty.
module ipm_prng_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q, wptr_d, rptr_d;
    logic [PW:0]      level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        head_d  = '0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop) level_d = level_q + 1'b1;
            if (pop && !push) level_d = level_q - 1'b1;
            // The new head may be the word being written this very cycle.
            if (level_d != '0) begin
                head_d = (push && (wptr_q == rptr_d)) ? wdata : mem_q[rptr_d];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush) mem_q[wptr_q] <= wdata;
    end

    assign rdata = head_q;
    assign level = level_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/ipm_prng.sv
// xorshift32 random-word source feeding a small FIFO with valid/ready pop and reseed strobe.
// Optional build macro IPM_PRNG_NONZERO_EN drops words containing a zero byte.
module ipm_prng
    import ibex_pkg::*;
#(
    parameter logic [31:0] SEED  = IPM_PRNG_DEFAULT_SEED,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     en_i,
    input  logic                     seed_valid_i,
    input  logic [31:0]              seed_i,
    output logic                     rnd_valid_o,
    input  logic                     rnd_ready_i,
    output logic [31:0]              rnd_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    logic [31:0] state_q;
    logic [31:0] step;
    logic        full, empty;
    logic        pop, advance, push;

    assign step    = ipm_xorshift32(state_q);
    assign pop     = rnd_valid_o && rnd_ready_i && !seed_valid_i;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign advance = en_i && !seed_valid_i && (!full || pop);

`ifdef IPM_PRNG_NONZERO_EN
    logic       word_ok;
    logic [7:0] reject_q;

    assign word_ok = (step[31:24] != '0) && (step[23:16] != '0) &&
                     (step[15:8]  != '0) && (step[7:0]   != '0);
    assign push    = advance && word_ok;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            reject_q <= '0;
        end else if (seed_valid_i) begin
            reject_q <= '0;
        end else if (advance && !word_ok && (reject_q != '1)) begin
            reject_q <= reject_q + 1'b1;
        end
    end
`else
    assign push = advance;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= SEED;
        end else if (seed_valid_i) begin
            state_q <= (seed_i == '0) ? SEED : seed_i;
        end else if (advance) begin
            state_q <= step;
        end
    end

    ipm_prng_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push     (push),
        .pop      (pop),
        .flush    (seed_valid_i),
        .wdata    (step),
        .rdata    (rnd_o),
        .full     (full),
        .empty    (empty),
        .level    (level_o)
    );

    assign rnd_valid_o = !empty;

endmodule

// File: tb/tb_ipm_prng.sv
// Directed self-checking bench for ipm_prng (default build; IPM_PRNG_NONZERO_EN selects the filter scenario).
module tb_ipm_prng;
    import ibex_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        seed_valid;
    logic [31:0] seed;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [31:0] rnd;
    logic [2:0]  level;

    int unsigned checks;
    int unsigned failures;
    logic [31:0] w [1:12];

    ipm_prng #(
        .SEED  (32'h0000_0001),
        .DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .en_i         (en),
        .seed_valid_i (seed_valid),
        .seed_i       (seed),
        .rnd_valid_o  (rnd_valid),
        .rnd_ready_i  (rnd_ready),
        .rnd_o        (rnd),
        .level_o      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; seed_valid = 1'b0; seed = '0; rnd_ready = 1'b0;
        #1;
        repeat (2) @(negedge clk);
        checks++;
        if (rnd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rnd_valid); end
        checks++;
        if (rnd !== 32'h0) begin failures++; $display("FAIL reset_rnd got=%h exp=00000000", rnd); end
        checks++;
        if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    endtask

    task automatic test_fill();
        reset_n = 1'b1; en = 1'b1; rnd_ready = 1'b0;
        tick();
        checks++;
        if (rnd !== 32'h0004_2021) begin failures++; $display("FAIL fill_first_word got=%h exp=00042021", rnd); end
        checks++;
        if (level !== 3'd1) begin failures++; $display("FAIL fill_level1 got=%0d exp=1", level); end
        checks++;
        if (rnd_valid !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b exp=1", rnd_valid); end
        repeat (3) tick();
        checks++;
        if (level !== 3'd4) begin failures++; $display("FAIL fill_level4 got=%0d exp=4", level); end
        repeat (2) tick();
        checks++;
        if (level !== 3'd4) begin failures++; $display("FAIL full_hold_level got=%0d exp=4", level); end
        checks++;
        if (rnd !== 32'h0004_2021) begin failures++; $display("FAIL full_hold_head got=%h exp=00042021", rnd); end
    endtask

    task automatic test_stream();
        rnd_ready = 1'b1;
        tick();
        checks++;
        if (rnd !== 32'h0408_0601) begin failures++; $display("FAIL stream_second_word got=%h exp=04080601", rnd); end
        for (int k = 2; k <= 6; k++) begin
            tick();
            checks++;
            if (rnd !== w[k+1]) begin failures++; $display("FAIL stream_word%0d got=%h exp=%h", k + 1, rnd, w[k+1]); end
            checks++;
            if (level !== 3'd4 || rnd_valid !== 1'b1) begin
                failures++; $display("FAIL stream_level got=%0d/%b exp=4/1", level, rnd_valid);
            end
        end
    endtask

    task automatic test_reseed();
        en = 1'b0; rnd_ready = 1'b1;
        tick();
        checks++;
        if (level !== 3'd3) begin failures++; $display("FAIL reseed_pre_level got=%0d exp=3", level); end
        seed_valid = 1'b1; seed = 32'h0; en = 1'b1;
        tick();
        checks++;
        if (level !== 3'd0 || rnd_valid !== 1'b0 || rnd !== 32'h0) begin
            failures++; $display("FAIL reseed_flush got=%0d/%b/%h exp=0/0/00000000", level, rnd_valid, rnd);
        end
        seed_valid = 1'b0;
        tick();
        checks++;
        if (rnd !== 32'h0004_2021 || level !== 3'd1) begin
            failures++; $display("FAIL reseed_first got=%h/%0d exp=00042021/1", rnd, level);
        end
        tick();
        checks++;
        if (rnd !== w[2] || level !== 3'd1) begin
            failures++; $display("FAIL reseed_second got=%h/%0d exp=%h/1", rnd, level, w[2]);
        end
    endtask

    task automatic test_stall();
        rnd_ready = 1'b0;
        tick();
        checks++;
        if (level !== 3'd2) begin failures++; $display("FAIL stall_pre_level got=%0d exp=2", level); end
        en = 1'b0; rnd_ready = 1'b1;
        tick();
        checks++;
        if (rnd !== w[3] || level !== 3'd1) begin
            failures++; $display("FAIL stall_pop1 got=%h/%0d exp=%h/1", rnd, level, w[3]);
        end
        tick();
        checks++;
        if (rnd_valid !== 1'b0 || rnd !== 32'h0 || level !== 3'd0) begin
            failures++; $display("FAIL stall_empty got=%b/%h/%0d exp=0/00000000/0", rnd_valid, rnd, level);
        end
        tick();
        checks++;
        if (level !== 3'd0) begin failures++; $display("FAIL stall_no_push got=%0d exp=0", level); end
        en = 1'b1; rnd_ready = 1'b0;
        tick();
        checks++;
        if (rnd !== w[4] || level !== 3'd1) begin
            failures++; $display("FAIL stall_resume got=%h/%0d exp=%h/1", rnd, level, w[4]);
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rnd_valid !== 1'b0 || rnd !== 32'h0 || level !== 3'd0) begin
            failures++; $display("FAIL async_reset got=%b/%h/%0d exp=0/00000000/0", rnd_valid, rnd, level);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if (rnd !== 32'h0004_2021 || level !== 3'd1) begin
            failures++; $display("FAIL async_restart got=%h/%0d exp=00042021/1", rnd, level);
        end
    endtask

    task automatic test_nonzero();
        logic [31:0] m;
        int unsigned got;
        reset_n = 1'b1;
        seed_valid = 1'b1; seed = 32'h0000_0100; en = 1'b1; rnd_ready = 1'b1;
        tick();
        seed_valid = 1'b0;
`ifdef IPM_PRNG_NONZERO_EN
        m = 32'h0000_0100;
        got = 0;
        for (int c = 0; c < 200 && got < 8; c++) begin
            tick();
            if (rnd_valid === 1'b1) begin
                do m = ipm_xorshift32(m);
                while (m[31:24] == 8'h0 || m[23:16] == 8'h0 || m[15:8] == 8'h0 || m[7:0] == 8'h0);
                got++;
                checks++;
                if (rnd !== m) begin failures++; $display("FAIL nonzero_word%0d got=%h exp=%h", got, rnd, m); end
                checks++;
                if (rnd[31:24] == 8'h0 || rnd[23:16] == 8'h0 || rnd[15:8] == 8'h0 || rnd[7:0] == 8'h0) begin
                    failures++; $display("FAIL nonzero_bytes got=%h exp=no zero byte", rnd);
                end
            end
        end
        checks++;
        if (got < 8) begin failures++; $display("FAIL nonzero_count got=%0d exp=8", got); end
`else
        m = 32'h0;
        got = 0;
        tick();
        checks++;
        if (rnd !== 32'h0420_2310) begin failures++; $display("FAIL seed100_word got=%h exp=04202310", rnd); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        w[1] = 32'h0004_2021;
        for (int i = 2; i <= 12; i++) w[i] = ipm_xorshift32(w[i-1]);
        test_reset();
`ifndef IPM_PRNG_NONZERO_EN
        test_fill();
        test_stream();
        test_reseed();
        test_stall();
        test_async_reset();
`endif
        test_nonzero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
